// File: rtl/ctr_pkg.sv
// ctr_pkg: shared widths and FSM state type for the AES-256-CTR block path
package ctr_pkg;
  localparam int BLK_W = 128;
  localparam int KEY_W = 256;
  localparam int CNT_W = 8;
  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, OUT} ctr_state_t;
endpackage

// File: rtl/ctr_counter.sv
// ctr_counter: loadable block counter with full-width wrap-around
module ctr_counter #(
  parameter int W = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         inc,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? d : inc ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign q = cnt_q;
endmodule

// File: rtl/ctr_block_scheduler.sv
// ctr_block_scheduler: issues counters to a shared AES core and XORs keystream into plaintext, one block in flight
module ctr_block_scheduler
  import ctr_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [KEY_W-1:0] key,
  input  logic [BLK_W-1:0] iv,
  input  logic [CNT_W-1:0] num_blocks,
  output logic             busy,
  output logic             done,
  input  logic             pt_valid,
  output logic             pt_ready,
  input  logic [BLK_W-1:0] pt_data,
  output logic             ct_valid,
  input  logic             ct_ready,
  output logic [BLK_W-1:0] ct_data,
  output logic             core_start,
  output logic [KEY_W-1:0] core_key,
  output logic [BLK_W-1:0] core_block,
  input  logic             core_done,
  input  logic [BLK_W-1:0] core_out
);
  ctr_state_t state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [BLK_W-1:0] pt_q, pt_d, ct_q, ct_d, ctr_q;
  logic busy_q, busy_d, done_q, done_d, ct_valid_q, ct_valid_d, core_start_q, core_start_d;
  logic ctr_load, ctr_inc;
  assign ctr_load = state_q == IDLE && start;
  assign ctr_inc = state_q == OUT && ct_ready;
  ctr_counter #(.W(BLK_W)) u_ctr (
    .clk (clk),
    .rst (rst),
    .load(ctr_load),
    .inc (ctr_inc),
    .d   (iv),
    .q   (ctr_q)
  );
  always_comb begin
    state_d = state_q;
    key_d = key_q;
    rem_d = rem_q;
    pt_d = pt_q;
    ct_d = ct_q;
    done_d = 1'b0;
    core_start_d = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        key_d = key;
        rem_d = num_blocks;
        done_d = num_blocks == '0;
        state_d = num_blocks == '0 ? IDLE : LOAD;
      end
      LOAD: if (pt_valid) begin
        pt_d = pt_data;
        core_start_d = 1'b1;
        state_d = ISSUE;
      end
      ISSUE: state_d = WAIT;
      WAIT: if (core_done) begin
        ct_d = pt_q ^ core_out;
        state_d = OUT;
      end
      OUT: if (ct_ready) begin
        rem_d = rem_q - CNT_W'(1);
        done_d = rem_q == CNT_W'(1);
        state_d = rem_q == CNT_W'(1) ? IDLE : LOAD;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
    ct_valid_d = state_d == OUT;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      key_q <= '0;
      rem_q <= '0;
      pt_q <= '0;
      ct_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ct_valid_q <= 1'b0;
      core_start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q <= key_d;
      rem_q <= rem_d;
      pt_q <= pt_d;
      ct_q <= ct_d;
      busy_q <= busy_d;
      done_q <= done_d;
      ct_valid_q <= ct_valid_d;
      core_start_q <= core_start_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign pt_ready = state_q == LOAD;
  assign ct_valid = ct_valid_q;
  assign ct_data = ct_q;
  assign core_start = core_start_q;
  assign core_key = key_q;
  assign core_block = ctr_q;
endmodule
